// File: rtl/fpu_tile_host_seq.sv
// fpu_tile_host_seq: initiator-side sequencer for the FPU IP tile register interface.
// It takes an add/sub command, loads data_reg_a/data_reg_b and raises the start bit in csr_in.
// It then waits for the tile's csr_out write and returns data_reg_c plus the status flags.
// Only one operation is in flight at a time.
//
// Ports:
//   clk, arst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_a/b   command stream (op 0 = add, 1 = sub)
//   rsp_valid/rsp_ready/rsp_data/flags   response stream (flags = csr_out[7:0])
//   csr_in, csr_in_re                    tile control word (bit15 start, bit4 op), tile read pulse
//   data_reg_a, data_reg_b               operands to the tile
//   csr_out, csr_out_we, data_reg_c      tile status word, write strobe, result
//   stray_err                            sticky: tile write seen while not awaiting one
//
// Optional feature: define FPU_HOST_TIMEOUT_EN to enable the watchdog.
// The watchdog returns a quiet NaN with flags 0x80 after TIMEOUT_CYCLES cycles
// without the awaited strobe.
module fpu_tile_host_seq #(
  parameter int unsigned CSR_IN_WIDTH   = 16,
  parameter int unsigned CSR_OUT_WIDTH  = 16,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [REG_WIDTH-1:0]     cmd_a,
  input  logic [REG_WIDTH-1:0]     cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [REG_WIDTH-1:0]     rsp_data,
  output logic [7:0]               rsp_flags,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic                     csr_in_re,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  output logic                     stray_err
);

  localparam int unsigned START_BIT = 15;
  localparam int unsigned OP_BIT    = 4;
  localparam int unsigned FLAG_W    = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state;

  // Only the low status byte is forwarded to the response stream.
  logic unused_csr_out_hi;
  assign unused_csr_out_hi = ^csr_out[CSR_OUT_WIDTH-1:FLAG_W];

  // Control word with the start bit set and the requested op; all other bits zero.
  function automatic logic [CSR_IN_WIDTH-1:0] start_word(input logic op);
    logic [CSR_IN_WIDTH-1:0] w;
    w            = '0;
    w[START_BIT] = 1'b1;
    w[OP_BIT]    = op;
    return w;
  endfunction

`ifdef FPU_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [REG_WIDTH-1:0] QNAN = REG_WIDTH'(32'h7FC0_0000);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      csr_in     <= '0;
      data_reg_a <= '0;
      data_reg_b <= '0;
      stray_err  <= 1'b0;
`ifdef FPU_HOST_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (csr_out_we) stray_err <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            data_reg_a <= cmd_a;
            data_reg_b <= cmd_b;
            csr_in     <= start_word(cmd_op);
            cmd_ready  <= 1'b0;
            state      <= S_ISSUE;
`ifdef FPU_HOST_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        // A result write wins over the read pulse: go straight to RESP.
        S_ISSUE: begin
          if (csr_out_we) begin
            csr_in    <= '0;
            rsp_data  <= data_reg_c;
            rsp_flags <= csr_out[FLAG_W-1:0];
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (csr_in_re) begin
            csr_in <= '0;
            state  <= S_WAIT;
`ifdef FPU_HOST_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            csr_in    <= '0;
            rsp_data  <= QNAN;
            rsp_flags <= 8'h80;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
          end
        end

        S_WAIT: begin
          if (csr_out_we) begin
            rsp_data  <= data_reg_c;
            rsp_flags <= csr_out[FLAG_W-1:0];
            rsp_valid <= 1'b1;
            state     <= S_RESP;
`ifdef FPU_HOST_TIMEOUT_EN
          end else if (tmo_hit) begin
            rsp_data  <= QNAN;
            rsp_flags <= 8'h80;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
          end
        end

        // Hold the response until consumed; cmd_ready returns from IDLE a cycle later.
        S_RESP: begin
          if (csr_out_we) stray_err <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_tile_host_seq.sv
// Directed self-checking bench for fpu_tile_host_seq.
// A hand-driven tile stub supplies csr_in_re / csr_out_we pulses.
module tb_fpu_tile_host_seq;

  logic        clk;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic [15:0] csr_in;
  logic        csr_in_re;
  logic [31:0] data_reg_a;
  logic [31:0] data_reg_b;
  logic [15:0] csr_out;
  logic        csr_out_we;
  logic [31:0] data_reg_c;
  logic        stray_err;

  int total = 0;
  int bad   = 0;

  fpu_tile_host_seq #(
    .CSR_IN_WIDTH  (16),
    .CSR_OUT_WIDTH (16),
    .REG_WIDTH     (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .csr_in    (csr_in),
    .csr_in_re (csr_in_re),
    .data_reg_a(data_reg_a),
    .data_reg_b(data_reg_b),
    .csr_out   (csr_out),
    .csr_out_we(csr_out_we),
    .data_reg_c(data_reg_c),
    .stray_err (stray_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle command handshake (cmd_ready must already be high).
  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; csr_in_re = 1'b0; csr_out = '0; csr_out_we = 1'b0; data_reg_c = '0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_csr_in", 32'(csr_in), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_stray", 32'(stray_err), 32'd0);
    arst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Add: 10.0 + 5.0
    send(1'b0, 32'h4120_0000, 32'h40A0_0000);
    chk("add_csr_in", 32'(csr_in), 32'h8000);
    chk("add_reg_a", data_reg_a, 32'h4120_0000);
    chk("add_reg_b", data_reg_b, 32'h40A0_0000);
    chk("add_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("add_csr_hold", 32'(csr_in), 32'h8000);
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;
    chk("add_csr_clr", 32'(csr_in), 32'd0);
    tick();
    chk("add_wait_noresp", 32'(rsp_valid), 32'd0);
    csr_out_we = 1'b1; csr_out = 16'h0001; data_reg_c = 32'h4170_0000;
    tick();
    csr_out_we = 1'b0;
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_data", rsp_data, 32'h4170_0000);
    chk("add_rsp_flags", 32'(rsp_flags), 32'h01);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("add_no_b2b", 32'(cmd_ready), 32'd0);
    tick();
    chk("add_ready_back", 32'(cmd_ready), 32'd1);

    // Sub: 14.0 - 5.0
    send(1'b1, 32'h4160_0000, 32'h40A0_0000);
    chk("sub_csr_in", 32'(csr_in), 32'h8010);
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;
    chk("sub_csr_clr", 32'(csr_in), 32'd0);
    chk("sub_reg_a_held", data_reg_a, 32'h4160_0000);
    csr_out_we = 1'b1; csr_out = 16'hFF00; data_reg_c = 32'h4110_0000;
    tick();
    csr_out_we = 1'b0;
    chk("sub_rsp_data", rsp_data, 32'h4110_0000);
    chk("sub_rsp_flags", 32'(rsp_flags), 32'h00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Simultaneous strobes one cycle after start, then backpressure
    send(1'b0, 32'h7F00_0000, 32'h7F00_0000);
    chk("sim_csr_in", 32'(csr_in), 32'h8000);
    csr_in_re = 1'b1; csr_out_we = 1'b1; csr_out = 16'h0085; data_reg_c = 32'h7F80_0000;
    tick();
    csr_in_re = 1'b0; csr_out_we = 1'b0;
    chk("sim_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sim_rsp_data", rsp_data, 32'h7F80_0000);
    chk("sim_rsp_flags", 32'(rsp_flags), 32'h85);
    chk("sim_csr_clr", 32'(csr_in), 32'd0);
    data_reg_c = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h7F80_0000);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Result write before the read pulse goes straight to RESP
    send(1'b1, 32'h3F80_0000, 32'h0000_0000);
    tick();
    csr_out_we = 1'b1; csr_out = 16'h0002; data_reg_c = 32'h3F80_0000;
    tick();
    csr_out_we = 1'b0;
    chk("early_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("early_rsp_flags", 32'(rsp_flags), 32'h02);
    chk("early_csr_clr", 32'(csr_in), 32'd0);
    chk("early_no_stray", 32'(stray_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Reset during WAIT, then the late tile result is stray
    send(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;
    tick();
    chk("wait_reg_a_held", data_reg_a, 32'h1234_5678);
    chk("wait_reg_b_held", data_reg_b, 32'h9ABC_DEF0);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_reg_a", data_reg_a, 32'd0);
    chk("arst_reg_b", data_reg_b, 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("arst_csr_in", 32'(csr_in), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick(); tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_stray", 32'(stray_err), 32'd0);
    csr_out_we = 1'b1; csr_out = 16'h0001; data_reg_c = 32'hDEAD_BEEF;
    tick();
    csr_out_we = 1'b0;
    chk("stray_set", 32'(stray_err), 32'd1);
    chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_no_data", rsp_data, 32'd0);
    tick();
    chk("stray_sticky", 32'(stray_err), 32'd1);

`ifdef FPU_HOST_TIMEOUT_EN
    // Watchdog: tile never responds
    send(1'b0, 32'h4000_0000, 32'h4000_0000);
    repeat (15) tick();
    chk("tmo_not_yet", 32'(rsp_valid), 32'd0);
    chk("tmo_csr_held", 32'(csr_in), 32'h8000);
    tick();
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_rsp_data", rsp_data, 32'h7FC0_0000);
    chk("tmo_rsp_flags", 32'(rsp_flags), 32'h80);
    chk("tmo_csr_clr", 32'(csr_in), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_tile_host_seq.md
Name: fpu_tile_host_seq

Overview:
- Initiator-side sequencer that drives the FPU IP tile CSR/data-register interface.
- Accepts add/sub commands on a valid/ready stream and loads operands into data_reg_a/data_reg_b.
- Asserts the start bit in csr_in, waits for the tile's csr_out write, then returns data_reg_c plus status flags on a valid/ready response stream.
- Sits between the system command fabric and the tile; one operation in flight at a time.

Parameters:
- CSR_IN_WIDTH, 16, width of csr_in.
- CSR_OUT_WIDTH, 16, width of csr_out.
- REG_WIDTH, 32, operand/result width (IEEE-754 single).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = add, 1 = sub
- cmd_a  in  REG_WIDTH  operand A
- cmd_b  in  REG_WIDTH  operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  REG_WIDTH  result captured from data_reg_c
- rsp_flags  out  8  csr_out[7:0] captured; bit 7 is forced to 1 on timeout
- csr_in  out  CSR_IN_WIDTH  bit15 = start, bit4 = op, all other bits 0
- csr_in_re  in  1  tile has read csr_in (1-cycle pulse)
- data_reg_a  out  REG_WIDTH  operand A to tile
- data_reg_b  out  REG_WIDTH  operand B to tile
- csr_out  in  CSR_OUT_WIDTH  tile status word
- csr_out_we  in  1  tile status/result write strobe (1-cycle pulse)
- data_reg_c  in  REG_WIDTH  tile result, valid while csr_out_we = 1
- stray_err  out  1  sticky; set by csr_out_we seen in IDLE or RESP

Behaviour:
- Reset values (async, arst_n = 0): state IDLE; csr_in, data_reg_a, data_reg_b, rsp_data and rsp_flags = 0; cmd_ready = 0; rsp_valid = 0; stray_err = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake: data_reg_a <= cmd_a, data_reg_b <= cmd_b, csr_in <= {start=1, op=cmd_op}; go to ISSUE.
  - Operands and csr_in change in the same cycle.
- ISSUE:
  - cmd_ready = 0; csr_in is held with start = 1.
  - On csr_in_re: csr_in <= 0 next cycle; go to WAIT.
  - If csr_out_we arrives in the same cycle as csr_in_re, or before it: clear csr_in, capture the result, go directly to RESP.
- WAIT:
  - data_reg_a and data_reg_b are held stable.
  - On csr_out_we: rsp_data <= data_reg_c, rsp_flags <= csr_out[7:0], rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid and rsp_data are held until rsp_ready.
  - On the handshake: rsp_valid <= 0; go to IDLE.
  - cmd_ready is reasserted the cycle after the response handshake, so there is no same-cycle back-to-back.
- csr_out_we in IDLE or RESP is ignored for data purposes and sets stray_err. stray_err clears only on reset.
- data_reg_a/data_reg_b keep their last values in IDLE; they are not cleared.
- Minimum latency, cmd handshake to rsp_valid: 2 cycles, when the tile raises csr_in_re and csr_out_we together one cycle after start.
- Reset mid-operation: returns to IDLE immediately. Any pending tile result arriving afterwards is treated as stray.

Optional Feature:
- Macro: FPU_HOST_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in ISSUE and WAIT and clears on entry to each of those states.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited strobe: csr_in <= 0, rsp_data <= 0x7FC00000, rsp_flags <= 0x80; go to RESP.
  - A late csr_out_we after a timeout sets stray_err.
- Disabled: no counter; the FSM waits indefinitely; rsp_flags[7] always reflects csr_out[7].

Test Plan:
- Add: cmd_a = 0x41200000, cmd_b = 0x40A00000, op = 0 -> csr_in = 0x8000 until csr_in_re; tile stub returns 0x41700000, flags 0x01 -> rsp_data = 0x41700000, rsp_flags = 0x01.
- Sub: 0x41600000 - 0x40A00000, op = 1 -> csr_in = 0x8010; stub returns 0x41100000 -> rsp_data = 0x41100000; csr_in = 0 from the cycle after csr_in_re.
- Simultaneous strobes: stub pulses csr_in_re and csr_out_we in the same cycle with data_reg_c = 0x7F800000 -> FSM goes ISSUE to RESP; rsp_valid the next cycle; no WAIT state.
- Backpressure: hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_data stable and cmd_ready = 0 throughout; release -> cmd_ready = 1 one cycle later.
- Stray and reset: csr_out_we in IDLE -> stray_err = 1, no rsp_valid. Assert arst_n = 0 during WAIT -> all outputs return to 0 asynchronously.
- With FPU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 16: the tile never strobes -> after 16 cycles, rsp_data = 0x7FC00000, rsp_flags = 0x80, csr_in = 0.
